// File: rtl/hub_ctrl_pkg.sv
// Shared definitions for the root hub round controller: FSM state encoding
// and the default round-length limits.
package hub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } round_state_t;

    // Hard upper bound on the length of one decoding round, in clk cycles.
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    // Consecutive cycles with no downstream traffic that count as a deadlock.
    localparam int DEFAULT_QUIET_LIMIT = 256;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear has priority over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/root_hub_round_controller.sv
// Sequences one decoding round of the root hub: accepts a host start request,
// pulses the hub, watches for convergence, traffic deadlock or timeout, and
// hands the round status back to the host over a valid/ready handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start_valid; last round status still visible
//   ST_START  | one-cycle new_round_start pulse to the root hub
//   ST_RUN    | counting cycles/iterations, watching result/quiet/timeout
//   ST_REPORT | done_valid held with frozen status until done_ready
module root_hub_round_controller
    import hub_ctrl_pkg::*;
#(
    parameter int NUM_CHILDREN            = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int CYCLE_COUNTER_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES          = DEFAULT_TIMEOUT_CYCLES,
    parameter int QUIET_LIMIT             = DEFAULT_QUIET_LIMIT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_valid,
    output logic                               start_ready,
    output logic                               new_round_start,
    input  logic                               iteration_done,
    input  logic                               hub_result_valid,
    input  logic [NUM_CHILDREN-1:0]            downstream_has_message_flying,
    input  logic [NUM_CHILDREN-1:0]            downstream_has_odd_clusters,
    output logic                               done_valid,
    input  logic                               done_ready,
    output logic                               deadlock,
    output logic                               odd_clusters_left,
    output logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic                               busy
);

    // The quiet counter only ever needs to reach QUIET_LIMIT-1.
    localparam int QUIET_WIDTH = (QUIET_LIMIT > 2) ? $clog2(QUIET_LIMIT) : 1;

    localparam logic [CYCLE_COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        CYCLE_COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [QUIET_WIDTH-1:0] QUIET_LAST =
        QUIET_WIDTH'(QUIET_LIMIT - 1);

    round_state_t           state;
    round_state_t           state_next;
    logic                   start_accept;
    logic                   in_run;
    logic                   all_quiet;
    logic                   quiet_hit;
    logic                   timeout_hit;
    logic                   report_enter;
    logic                   report_deadlock;
    logic [QUIET_WIDTH-1:0] quiet_count;

    assign in_run       = (state == ST_RUN);
    assign start_accept = start_ready && start_valid;
    assign all_quiet    = ~|downstream_has_message_flying;
    assign quiet_hit    = all_quiet && (quiet_count == QUIET_LAST);
    assign timeout_hit  = (cycle_counter == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a converged result beats deadlock.
    always_comb begin
        state_next      = state;
        start_ready     = 1'b0;
        new_round_start = 1'b0;
        done_valid      = 1'b0;
        busy            = 1'b1;
        report_enter    = 1'b0;
        report_deadlock = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                new_round_start = 1'b1;
                state_next      = ST_RUN;
            end
            ST_RUN: begin
                if (hub_result_valid) begin
                    state_next      = ST_REPORT;
                    report_enter    = 1'b1;
                    report_deadlock = 1'b0;
                end else if (quiet_hit || timeout_hit) begin
                    state_next      = ST_REPORT;
                    report_enter    = 1'b1;
                    report_deadlock = 1'b1;
                end
            end
            ST_REPORT: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Round status: cleared when a new round is accepted, captured on the
    // RUN->REPORT transition and then frozen until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deadlock          <= 1'b0;
            odd_clusters_left <= 1'b0;
        end else if (start_accept) begin
            deadlock          <= 1'b0;
            odd_clusters_left <= 1'b0;
        end else if (report_enter) begin
            deadlock          <= report_deadlock;
            odd_clusters_left <= |downstream_has_odd_clusters;
        end
    end

    saturating_counter #(
        .WIDTH (CYCLE_COUNTER_WIDTH)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_accept),
        .inc   (in_run),
        .count (cycle_counter)
    );

    saturating_counter #(
        .WIDTH (ITERATION_COUNTER_WIDTH)
    ) u_iteration_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_accept),
        .inc   (in_run && iteration_done),
        .count (iteration_counter)
    );

    // Any traffic in flight restarts the quiet window.
    saturating_counter #(
        .WIDTH (QUIET_WIDTH)
    ) u_quiet_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_accept || (in_run && !all_quiet)),
        .inc   (in_run && all_quiet),
        .count (quiet_count)
    );

endmodule

// File: tb/tb_root_hub_round_controller.sv
// Directed bench for root_hub_round_controller with a scoreboard: the stimulus
// thread queues the expected start pulses and round reports, a monitor on the
// falling edge pops and compares whenever the DUT presents them.
module tb_root_hub_round_controller;

    localparam int NC = 2;
    localparam int IW = 8;
    localparam int CW = 32;

    typedef struct {
        int     cyc;
        bit     dl;
        bit     odd;
        longint cc;
        longint ic;
        int     len;
    } rep_t;

    logic          clk;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic          new_round_start;
    logic          iteration_done;
    logic          hub_result_valid;
    logic [NC-1:0] flying;
    logic [NC-1:0] odd;
    logic          done_valid;
    logic          done_ready;
    logic          deadlock;
    logic          odd_clusters_left;
    logic [CW-1:0] cycle_counter;
    logic [IW-1:0] iteration_counter;
    logic          busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_q[$];
    rep_t rep_q[$];
    rep_t cur;
    bit   in_rep = 0;
    bit   have_exp = 0;
    int   rep_len = 0;
    int   exp_start;

    root_hub_round_controller #(
        .NUM_CHILDREN            (NC),
        .ITERATION_COUNTER_WIDTH (IW),
        .CYCLE_COUNTER_WIDTH     (CW),
        .TIMEOUT_CYCLES          (50),
        .QUIET_LIMIT             (4)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .start_valid                   (start_valid),
        .start_ready                   (start_ready),
        .new_round_start               (new_round_start),
        .iteration_done                (iteration_done),
        .hub_result_valid              (hub_result_valid),
        .downstream_has_message_flying (flying),
        .downstream_has_odd_clusters   (odd),
        .done_valid                    (done_valid),
        .done_ready                    (done_ready),
        .deadlock                      (deadlock),
        .odd_clusters_left             (odd_clusters_left),
        .cycle_counter                 (cycle_counter),
        .iteration_counter             (iteration_counter),
        .busy                          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to 1 ns after the rising edge that starts cycle n.
    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_start(input int n);
        at(n);
        start_valid = 1'b1;
        start_q.push_back(n + 1);
        at(n + 1);
        start_valid = 1'b0;
    endtask

    task automatic push_rep(input int c, input bit dl, input bit od,
                            input longint cc, input longint ic, input int len);
        rep_t r;
        r.cyc = c; r.dl = dl; r.odd = od; r.cc = cc; r.ic = ic; r.len = len;
        rep_q.push_back(r);
    endtask

    // Monitor: start pulses and round reports, compared against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (new_round_start) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_new_round_start", cyc, -1);
                end else begin
                    exp_start = start_q.pop_front();
                    chk("new_round_start_cycle", cyc, exp_start);
                end
            end
            if (done_valid) begin
                if (!in_rep) begin
                    in_rep  = 1;
                    rep_len = 0;
                    if (rep_q.size() == 0) begin
                        have_exp = 0;
                        chk("unexpected_done_valid", cyc, -1);
                    end else begin
                        cur      = rep_q.pop_front();
                        have_exp = 1;
                        chk("done_valid_cycle", cyc, cur.cyc);
                    end
                end
                rep_len++;
                if (have_exp) begin
                    chk("deadlock", deadlock, cur.dl);
                    chk("odd_clusters_left", odd_clusters_left, cur.odd);
                    chk("cycle_counter", cycle_counter, cur.cc);
                    chk("iteration_counter", iteration_counter, cur.ic);
                    chk("busy_in_report", busy, 1);
                end
            end else if (in_rep) begin
                in_rep = 0;
                if (have_exp) chk("report_length", rep_len, cur.len);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        start_valid      = 1'b0;
        iteration_done   = 1'b0;
        hub_result_valid = 1'b0;
        flying           = 2'b11;
        odd              = 2'b00;
        done_ready       = 1'b1;

        // Reset state.
        at(2);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_new_round_start", new_round_start, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_cycle_counter", cycle_counter, 0);
        chk("rst_iteration_counter", iteration_counter, 0);
        chk("rst_deadlock", deadlock, 0);
        chk("rst_odd", odd_clusters_left, 0);
        at(3);
        reset = 1'b1;

        // Start at 10 (held to 15, extra cycles ignored), result at 40.
        push_rep(41, 0, 0, 29, 0, 1);
        at(10);
        start_valid = 1'b1;
        start_q.push_back(11);
        at(16);
        start_valid = 1'b0;
        at(40);
        hub_result_valid = 1'b1;
        at(41);
        hub_result_valid = 1'b0;
        at(50);
        chk("idle_hold_cycle_counter", cycle_counter, 29);
        chk("idle_hold_deadlock", deadlock, 0);
        chk("idle_busy", busy, 0);
        chk("idle_start_ready", start_ready, 1);

        // Quiet deadlock after four quiet RUN cycles.
        at(55);
        flying = 2'b00;
        push_rep(66, 1, 0, 4, 0, 1);
        issue_start(60);
        at(75);
        chk("idle_hold_deadlock_1", deadlock, 1);
        chk("idle_hold_cycle_counter_4", cycle_counter, 4);

        // Traffic in one RUN cycle restarts the quiet window.
        push_rep(88, 1, 0, 6, 0, 1);
        issue_start(80);
        at(83);
        flying = 2'b01;
        at(84);
        flying = 2'b00;

        // Result coincides with the quiet limit: result wins.
        push_rep(106, 0, 0, 4, 0, 1);
        issue_start(100);
        at(105);
        hub_result_valid = 1'b1;
        at(106);
        hub_result_valid = 1'b0;
        at(110);
        flying = 2'b11;

        // Iteration pulses in IDLE/START ignored, three in RUN counted;
        // done_ready held low for five REPORT cycles while inputs wiggle.
        at(118);
        iteration_done = 1'b1;
        at(119);
        iteration_done = 1'b0;
        push_rep(136, 0, 0, 14, 3, 6);
        issue_start(120);
        iteration_done = 1'b1;
        at(122);
        iteration_done = 1'b0;
        at(124);
        iteration_done = 1'b1;
        at(126);
        iteration_done = 1'b0;
        at(130);
        iteration_done = 1'b1;
        done_ready     = 1'b0;
        at(131);
        iteration_done = 1'b0;
        at(135);
        hub_result_valid = 1'b1;
        at(136);
        hub_result_valid = 1'b0;
        odd              = 2'b11;
        at(137);
        iteration_done = 1'b1;
        flying         = 2'b00;
        at(138);
        iteration_done   = 1'b0;
        hub_result_valid = 1'b1;
        at(139);
        hub_result_valid = 1'b0;
        flying           = 2'b11;
        at(141);
        done_ready = 1'b1;
        at(142);
        odd = 2'b00;

        // Odd-cluster flags 2'b10 at the result cycle.
        push_rep(161, 0, 1, 9, 0, 1);
        issue_start(150);
        at(160);
        hub_result_valid = 1'b1;
        odd              = 2'b10;
        at(161);
        hub_result_valid = 1'b0;
        odd              = 2'b00;

        // Timeout with traffic always flying.
        push_rep(222, 1, 0, 50, 0, 1);
        issue_start(170);

        // Reset asserted mid-cycle during RUN aborts the round.
        issue_start(240);
        at(245);
        iteration_done = 1'b1;
        at(246);
        iteration_done = 1'b0;
        at(250);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done_valid", done_valid, 0);
        chk("abort_new_round_start", new_round_start, 0);
        chk("abort_cycle_counter", cycle_counter, 0);
        chk("abort_iteration_counter", iteration_counter, 0);
        chk("abort_deadlock", deadlock, 0);
        chk("abort_odd", odd_clusters_left, 0);
        at(253);
        reset = 1'b1;
        #2;
        chk("post_reset_start_ready", start_ready, 1);
        chk("post_reset_busy", busy, 0);

        // Normal round after the abort.
        push_rep(266, 0, 0, 4, 0, 1);
        issue_start(260);
        at(265);
        hub_result_valid = 1'b1;
        at(266);
        hub_result_valid = 1'b0;

        at(280);
        chk("pending_start_pulses", start_q.size(), 0);
        chk("pending_reports", rep_q.size(), 0);
        chk("report_still_open", in_rep, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/root_hub_round_controller.md
ROOT_HUB_ROUND_CONTROLLER -- requirements
Module: root_hub_round_controller

Interface
REQ-001 SHALL have parameter NUM_CHILDREN, default 2, number of downstream hub links monitored.
REQ-002 SHALL have parameter ITERATION_COUNTER_WIDTH, default 8, width of iteration count.
REQ-003 SHALL have parameter CYCLE_COUNTER_WIDTH, default 32, width of cycle count.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, hard round-length limit in cycles (>=2).
REQ-005 SHALL have parameter QUIET_LIMIT, default 256, consecutive no-traffic cycles that declare deadlock (>=2).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start_valid / start_ready  input / output  1 / 1  host request to begin one decoding round.
REQ-009 new_round_start  output  1  single-cycle pulse to the root hub.
REQ-010 iteration_done  input  1  one-cycle pulse from hub per completed grow/merge iteration.
REQ-011 hub_result_valid  input  1  hub reports decoding converged.
REQ-012 downstream_has_message_flying  input  NUM_CHILDREN  per-child traffic-in-flight flags.
REQ-013 downstream_has_odd_clusters  input  NUM_CHILDREN  per-child odd-cluster flags.
REQ-014 done_valid / done_ready  output / input  1 / 1  round-status handshake to host.
REQ-015 deadlock, odd_clusters_left  output  1 each  status of finished round.
REQ-016 cycle_counter  output  CYCLE_COUNTER_WIDTH; iteration_counter  output  ITERATION_COUNTER_WIDTH.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, START, RUN, REPORT.
REQ-019 IDLE: start_ready=1; start_valid high -> START next cycle, cycle_counter, iteration_counter, quiet counter, status cleared.
REQ-020 START: new_round_start=1 for exactly one cycle, start_ready=0; -> RUN unconditionally.
REQ-021 RUN: cycle_counter increments by 1 per cycle, saturating at all-ones.
REQ-022 RUN: iteration_done increments iteration_counter, saturating at all-ones; pulses outside RUN ignored.
REQ-023 RUN: quiet counter increments when all downstream_has_message_flying bits are 0, clears to 0 otherwise.
REQ-024 RUN: hub_result_valid=1 -> REPORT with deadlock=0.
REQ-025 RUN: quiet counter reaching QUIET_LIMIT-1 while quiet, or cycle_counter reaching TIMEOUT_CYCLES-1, -> REPORT with deadlock=1.
REQ-026 Simultaneous result and timeout/quiet in same cycle: result SHALL win, deadlock=0.
REQ-027 On entry to REPORT, odd_clusters_left SHALL latch OR-reduction of downstream_has_odd_clusters.
REQ-028 REPORT: done_valid=1; deadlock, odd_clusters_left, cycle_counter, iteration_counter held stable until done_valid&&done_ready; then -> IDLE.
REQ-029 done_ready asserted outside REPORT SHALL have no effect; start_valid outside IDLE SHALL be ignored (not queued).
REQ-030 Latency: start handshake at cycle N -> new_round_start at N+1; hub_result_valid at cycle M -> done_valid at M+1.
REQ-031 Status outputs and counters SHALL remain at last reported values in IDLE until next start accepted.

Reset
REQ-032 reset=0 SHALL asynchronously force state IDLE, all counters 0, new_round_start=0, done_valid=0, deadlock=0, odd_clusters_left=0, busy=0.
REQ-033 Reset mid-round SHALL abort without emitting done_valid; start_ready=1 first cycle after deassertion.

Structure
REQ-034 State enum and default TIMEOUT/QUIET constants SHALL live in shared package hub_ctrl_pkg.
REQ-035 Single sub-module saturating_counter (parameterised width, inc, clear) SHALL implement cycle, iteration and quiet counters.

Verification
REQ-036 Start at cycle 10, result_valid at cycle 40 -> new_round_start pulse at 11, done_valid at 41, deadlock=0, cycle_counter=29.
REQ-037 QUIET_LIMIT=4, flying flags all 0 after START, no result -> done_valid with deadlock=1 after 4 RUN cycles.
REQ-038 Result and quiet limit same cycle -> deadlock=0.
REQ-039 Three iteration_done pulses in RUN plus one in IDLE -> iteration_counter=3; done_ready held low 5 cycles -> outputs stable throughout.
REQ-040 reset=0 asserted in RUN mid-cycle -> outputs cleared immediately, no done_valid, start_ready=1 after release; odd flags 2'b10 at result -> odd_clusters_left=1.
